load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum MEM-state cycles to wait for mem_ack before flagging an error.
REQ-002 SHALL have port clk, in, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, in, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have ports req_valid in 1 and req_ready out 1: the upstream handshake.
REQ-005 SHALL have ports insn_type in 3, funct3 in 3, addr in 32 (the ALU result), store_data in 32 (rs2), and rd_in in 5.
REQ-006 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_be out 4, mem_ack in 1, and mem_rdata in 32.
REQ-007 SHALL have ports resp_valid out 1, resp_ready in 1, resp_data out 32, resp_rd out 5, and resp_err out 1: the downstream writeback handshake.

Function
REQ-008 SHALL implement a three-state FSM: IDLE, MEM, RESP.
REQ-009 SHALL drive req_ready=1 only in IDLE; a transfer occurs when req_valid and req_ready are both 1, and all request fields are captured at that edge.
REQ-010 In IDLE, on transfer with insn_type 3'b011 (load) or 3'b010 (store) and a legal access, SHALL go to MEM.
REQ-011 In IDLE, on transfer with any other insn_type, SHALL go to RESP with resp_data=addr and resp_err=0 (ALU pass-through, no memory access, 1-cycle latency).
REQ-012 SHALL treat load funct3 000/001/010/100/101 (LB/LH/LW/LBU/LHU) and store funct3 000/001/010 (SB/SH/SW) as legal; any other funct3 goes directly to RESP with resp_err=1 and resp_data=0, with no mem_req.
REQ-013 In MEM, SHALL hold mem_req=1 with stable mem_addr={addr[31:2],2'b00}, mem_we (1 for store), mem_be and mem_wdata until mem_ack=1 is sampled, then go to RESP.
REQ-014 For stores, mem_be SHALL be 4'b0001<<addr[1:0] for SB, 4'b0011<<{addr[1],1'b0} for SH, and 4'b1111 for SW.
REQ-015 For stores, mem_wdata SHALL carry the byte replicated 4x for SB, the halfword replicated 2x for SH, and store_data for SW.
REQ-016 For loads, mem_be SHALL be 4'b1111; the selected lane SHALL be sign-extended for LB/LH, zero-extended for LBU/LHU, and taken whole for LW, and captured into resp_data on the ack edge.
REQ-017 For stores, resp_data SHALL be 0.
REQ-018 In MEM, SHALL count cycles; if TIMEOUT_CYCLES cycles elapse without mem_ack, SHALL drop mem_req and go to RESP with resp_err=1 and resp_data=0.
REQ-019 SHALL ignore mem_ack outside MEM.
REQ-020 In RESP, SHALL hold resp_valid=1 with resp_data, resp_rd=rd_in and resp_err stable until resp_ready=1, then return to IDLE; there is no back-to-back accept in the RESP cycle.
REQ-021 Load latency SHALL be: accept edge, then mem_req is high from the next cycle, then resp_valid is high in the cycle after the mem_ack edge.

Reset
REQ-022 While rst_n=0, SHALL force state=IDLE, cycle counter=0, and req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_valid, resp_data, resp_rd and resp_err all to 0.
REQ-023 Reset asserted mid-transaction SHALL immediately drop mem_req and resp_valid and abandon the access; req_ready SHALL return to 1 on the first edge after release.

Configuration
REQ-024 SHALL support macro LSU_MISALIGN_CHECK_EN.
REQ-025 With LSU_MISALIGN_CHECK_EN defined, SHALL treat LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0 as misaligned: go to RESP with resp_err=1, resp_data=0, and no mem_req.
REQ-026 With LSU_MISALIGN_CHECK_EN undefined, SHALL silently truncate: halfword accesses use addr[1] only, word accesses ignore addr[1:0], and no misalignment error is raised.

Structure
REQ-027 Package lsu_pkg SHALL hold the insn_type encodings (I-arith 000, R-arith 001, store 010, load 011, jump 101, branch 110), the load/store funct3 constants and the FSM state enum.
REQ-028 Combinational lane logic (mem_be, mem_wdata replication, load extract/extend) SHALL live in sub-module lsu_align; load_store_unit holds the FSM, counter and registers.

Verification
REQ-029 SB addr=0x1003, store_data=0x000000AB -> mem_addr=0x1000, mem_be=4'b1000, mem_wdata=0xABABABAB, mem_we=1; after ack, resp_err=0 and resp_data=0.
REQ-030 LB addr=0x2001, mem_rdata=0x0000F000 -> resp_data=0xFFFFFFF0; LBU with the same stimulus -> resp_data=0x000000F0.
REQ-031 LH addr=0x3002, mem_rdata=0x80010000 -> resp_data=0xFFFF8001; LW addr=0x3002 with macro defined -> resp_err=1 and no mem_req; with macro undefined -> mem_addr=0x3000 and resp_err=0.
REQ-032 Load with mem_ack held low and TIMEOUT_CYCLES=16 -> mem_req falls after 16 cycles, then resp_valid=1, resp_err=1, resp_data=0.
REQ-033 insn_type=3'b001, addr=0x12345678, rd_in=5 -> resp_valid the next cycle with resp_data=0x12345678 and resp_rd=5; with resp_ready held low for 3 cycles, outputs stay stable and req_ready=0 throughout.
REQ-034 rst_n pulled low while in MEM -> mem_req=0 immediately; after release, req_ready=1 and a new LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, funct3 constants and FSM state type for the load/store unit
package lsu_pkg;

    localparam logic [2:0] INSN_I_ARITH = 3'b000;
    localparam logic [2:0] INSN_R_ARITH = 3'b001;
    localparam logic [2:0] INSN_STORE   = 3'b010;
    localparam logic [2:0] INSN_LOAD    = 3'b011;
    localparam logic [2:0] INSN_JUMP    = 3'b101;
    localparam logic [2:0] INSN_BRANCH  = 3'b110;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane enables, store data replication and load lane extract/extend
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [1:0]  st_addr_lo,
    input  logic [2:0]  st_funct3,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [1:0]  ld_addr_lo,
    input  logic [2:0]  ld_funct3,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        if (is_store) begin
            case (st_funct3)
                F3_B: begin
                    be    = 4'b0001 << st_addr_lo;
                    wdata = {4{store_data[7:0]}};
                end
                F3_H: begin
                    be    = 4'b0011 << {st_addr_lo[1], 1'b0};
                    wdata = {2{store_data[15:0]}};
                end
                default: begin
                    be    = 4'b1111;
                    wdata = store_data;
                end
            endcase
        end
    end

    // Halfword lane uses addr[1] only, so a misaligned halfword silently truncates.
    always_comb begin
        ld_byte = 8'h00;
        case (ld_addr_lo)
            2'd0: ld_byte = rdata[7:0];
            2'd1: ld_byte = rdata[15:8];
            2'd2: ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];

        load_data = 32'h0;
        case (ld_funct3)
            F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   load_data = {24'h0, ld_byte};
            F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   load_data = {16'h0, ld_half};
            F3_W:    load_data = rdata;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - LSU FSM, timeout counter and request/response registers; LSU_MISALIGN_CHECK_EN enables misalignment errors
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  insn_type,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e state, next_state;

    logic [CW-1:0] cnt;
    logic          rdy_q;
    logic [1:0]    addr_lo_q;
    logic [2:0]    funct3_q;
    logic          accept;
    logic          is_mem;
    logic          is_store;
    logic          legal;
    logic          misaligned;
    logic          timeout;
    logic [3:0]    be_next;
    logic [31:0]   wdata_next;
    logic [31:0]   load_data;

    assign is_store = (insn_type == INSN_STORE);
    assign is_mem   = is_store || (insn_type == INSN_LOAD);
    assign legal    = f3_legal(is_store, funct3);
    assign timeout  = (cnt == CNT_LAST);

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
                        ((funct3 == F3_W) && (addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    lsu_align u_align (
        .is_store   (is_store),
        .st_addr_lo (addr[1:0]),
        .st_funct3  (funct3),
        .store_data (store_data),
        .be         (be_next),
        .wdata      (wdata_next),
        .ld_addr_lo (addr_lo_q),
        .ld_funct3  (funct3_q),
        .rdata      (mem_rdata),
        .load_data  (load_data)
    );

    // rdy_q keeps req_ready low while reset is held and for no longer than the first edge after.
    assign req_ready  = (state == ST_IDLE) && rdy_q;
    assign mem_req    = (state == ST_MEM);
    assign resp_valid = (state == ST_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid && rdy_q) begin
                    accept = 1'b1;
                    if (is_mem && legal && !misaligned) next_state = ST_MEM;
                    else                                next_state = ST_RESP;
                end
            end
            ST_MEM:  if (mem_ack || timeout) next_state = ST_RESP;
            ST_RESP: if (resp_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q     <= 1'b0;
            cnt       <= '0;
            addr_lo_q <= 2'b00;
            funct3_q  <= 3'b000;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'h0;
            resp_data <= 32'h0;
            resp_rd   <= 5'h0;
            resp_err  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (state == ST_MEM && next_state == ST_MEM) cnt <= cnt + 1'b1;
            else                                         cnt <= '0;

            if (accept) begin
                resp_rd <= rd_in;
                if (!is_mem) begin
                    resp_data <= addr;
                    resp_err  <= 1'b0;
                end else if (legal && !misaligned) begin
                    addr_lo_q <= addr[1:0];
                    funct3_q  <= funct3;
                    mem_we    <= is_store;
                    mem_addr  <= {addr[31:2], 2'b00};
                    mem_wdata <= wdata_next;
                    mem_be    <= be_next;
                    resp_data <= 32'h0;
                    resp_err  <= 1'b0;
                end else begin
                    resp_data <= 32'h0;
                    resp_err  <= 1'b1;
                end
            end

            if (state == ST_MEM) begin
                if (mem_ack) begin
                    if (!mem_we) resp_data <= load_data;
                end else if (timeout) begin
                    resp_data <= 32'h0;
                    resp_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  insn_type;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;

    int n_tests = 0;
    int n_fail  = 0;
    int hi_cnt;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .insn_type  (insn_type),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .rd_in      (rd_in),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] t, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rd);
        req_valid  = 1'b1;
        insn_type  = t;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        rd_in      = rd;
        step();
        req_valid  = 1'b0;
    endtask

    task automatic ack(input logic [31:0] rdata);
        mem_rdata = rdata;
        mem_ack   = 1'b1;
        step();
        mem_ack   = 1'b0;
    endtask

    task automatic drain();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; insn_type = 3'b0; funct3 = 3'b0; addr = 32'h0;
        store_data = 32'h0; rd_in = 5'h0; mem_ack = 1'b0; mem_rdata = 32'h0; resp_ready = 1'b0;
        step();
        step();
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", {31'h0, req_ready}, 32'h1);

        // SB
        issue(3'b010, 3'b000, 32'h0000_1003, 32'h0000_00AB, 5'd1);
        chk("sb_mem_req", {31'h0, mem_req}, 32'h1);
        chk("sb_mem_addr", mem_addr, 32'h0000_1000);
        chk("sb_mem_be", {28'h0, mem_be}, 32'h8);
        chk("sb_mem_wdata", mem_wdata, 32'hABAB_ABAB);
        chk("sb_mem_we", {31'h0, mem_we}, 32'h1);
        chk("sb_req_ready_busy", {31'h0, req_ready}, 32'h0);
        ack(32'hFFFF_FFFF);
        chk("sb_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("sb_resp_err", {31'h0, resp_err}, 32'h0);
        chk("sb_resp_data", resp_data, 32'h0);
        drain();
        chk("sb_back_idle", {31'h0, req_ready}, 32'h1);

        // SH and SW lane enables / replication
        issue(3'b010, 3'b001, 32'h0000_1002, 32'h1234_ABCD, 5'd2);
        chk("sh_mem_be", {28'h0, mem_be}, 32'hC);
        chk("sh_mem_wdata", mem_wdata, 32'hABCD_ABCD);
        ack(32'h0);
        drain();
        issue(3'b010, 3'b010, 32'h0000_1008, 32'h1234_ABCD, 5'd2);
        chk("sw_mem_be", {28'h0, mem_be}, 32'hF);
        chk("sw_mem_wdata", mem_wdata, 32'h1234_ABCD);
        ack(32'h0);
        drain();

        // LB / LBU
        issue(3'b011, 3'b000, 32'h0000_2001, 32'h0, 5'd3);
        chk("lb_mem_we", {31'h0, mem_we}, 32'h0);
        chk("lb_mem_be", {28'h0, mem_be}, 32'hF);
        chk("lb_mem_addr", mem_addr, 32'h0000_2000);
        ack(32'h0000_F000);
        chk("lb_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("lb_resp_data", resp_data, 32'hFFFF_FFF0);
        chk("lb_resp_rd", {27'h0, resp_rd}, 32'd3);
        drain();
        issue(3'b011, 3'b100, 32'h0000_2001, 32'h0, 5'd4);
        ack(32'h0000_F000);
        chk("lbu_resp_data", resp_data, 32'h0000_00F0);
        drain();

        // LH
        issue(3'b011, 3'b001, 32'h0000_3002, 32'h0, 5'd6);
        ack(32'h8001_0000);
        chk("lh_resp_data", resp_data, 32'hFFFF_8001);
        chk("lh_resp_err", {31'h0, resp_err}, 32'h0);
        drain();

        // LW misaligned
        issue(3'b011, 3'b010, 32'h0000_3002, 32'h0, 5'd7);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("lw_mis_mem_req", {31'h0, mem_req}, 32'h0);
        chk("lw_mis_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("lw_mis_resp_err", {31'h0, resp_err}, 32'h1);
        chk("lw_mis_resp_data", resp_data, 32'h0);
`else
        chk("lw_trunc_mem_req", {31'h0, mem_req}, 32'h1);
        chk("lw_trunc_mem_addr", mem_addr, 32'h0000_3000);
        ack(32'hDEAD_BEEF);
        chk("lw_trunc_resp_err", {31'h0, resp_err}, 32'h0);
        chk("lw_trunc_resp_data", resp_data, 32'hDEAD_BEEF);
`endif
        drain();

        // illegal funct3
        issue(3'b011, 3'b011, 32'h0000_4000, 32'h0, 5'd8);
        chk("ill_ld_mem_req", {31'h0, mem_req}, 32'h0);
        chk("ill_ld_resp_err", {31'h0, resp_err}, 32'h1);
        chk("ill_ld_resp_data", resp_data, 32'h0);
        drain();
        issue(3'b010, 3'b100, 32'h0000_4000, 32'h5555_5555, 5'd8);
        chk("ill_st_mem_req", {31'h0, mem_req}, 32'h0);
        chk("ill_st_resp_err", {31'h0, resp_err}, 32'h1);
        drain();

        // timeout
        issue(3'b011, 3'b010, 32'h0000_4000, 32'h0, 5'd9);
        hi_cnt = 0;
        for (int i = 0; i < 40 && mem_req; i++) begin
            hi_cnt++;
            step();
        end
        chk("to_mem_req_cycles", hi_cnt, 32'd16);
        chk("to_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("to_resp_err", {31'h0, resp_err}, 32'h1);
        chk("to_resp_data", resp_data, 32'h0);
        drain();

        // ALU pass-through with stalled writeback
        issue(3'b001, 3'b000, 32'h1234_5678, 32'h0, 5'd5);
        chk("alu_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("alu_mem_req", {31'h0, mem_req}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("alu_hold_data", resp_data, 32'h1234_5678);
            chk("alu_hold_rd", {27'h0, resp_rd}, 32'd5);
            chk("alu_hold_valid", {31'h0, resp_valid}, 32'h1);
            chk("alu_hold_err", {31'h0, resp_err}, 32'h0);
            chk("alu_hold_ready", {31'h0, req_ready}, 32'h0);
            step();
        end
        drain();
        chk("alu_back_idle", {31'h0, req_ready}, 32'h1);

        // reset in MEM
        issue(3'b011, 3'b010, 32'h0000_5000, 32'h0, 5'd10);
        chk("rmid_mem_req_pre", {31'h0, mem_req}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_mem_req_drop", {31'h0, mem_req}, 32'h0);
        chk("rmid_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rmid_req_ready", {31'h0, req_ready}, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("rmid_ready_after", {31'h0, req_ready}, 32'h1);
        issue(3'b011, 3'b010, 32'h0000_6004, 32'h0, 5'd11);
        chk("rmid_lw_mem_addr", mem_addr, 32'h0000_6004);
        ack(32'h1122_3344);
        chk("rmid_lw_data", resp_data, 32'h1122_3344);
        chk("rmid_lw_rd", {27'h0, resp_rd}, 32'd11);
        chk("rmid_lw_err", {31'h0, resp_err}, 32'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
